count_enable_ctrl: RTL and testbench

COUNT_ENABLE_CTRL -- requirements
Module: count_enable_ctrl

---
 rtl/count_enable_ctrl_if.sv | 22 ++
 rtl/count_enable_ctrl.sv | 106 ++++++++++
 tb/tb_count_enable_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/count_enable_ctrl_if.sv
// Button inputs and count-enable outputs of the count-enable controller.
// The master drives the raw buttons; the slave (the controller) drives Enable/Running.
interface count_enable_ctrl_if;
  logic Btn_run;
  logic Btn_step;
  logic Enable;
  logic Running;

  modport master (
    output Btn_run,
    output Btn_step,
    input  Enable,
    input  Running
  );

  modport slave (
    input  Btn_run,
    input  Btn_step,
    output Enable,
    output Running
  );
endinterface

// File: rtl/count_enable_ctrl.sv
// Start/stop and single-step controller producing a prescaled count-enable pulse
// for a downstream T-flip-flop counter, with synchronised and debounced buttons.
module count_enable_ctrl #(
  parameter int DIV       = 10,
  parameter int DB_CYCLES = 4
) (
  input  logic              Clk,
  input  logic              Clr,
  count_enable_ctrl_if.slave bus
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  localparam logic [0:0] STOPPED = 1'b0;
  localparam logic [0:0] RUN     = 1'b1;

  localparam int BTN_RUN  = 0;
  localparam int BTN_STEP = 1;

  logic [1:0]    raw;
  logic [1:0]    sync1;
  logic [1:0]    sync2;
  logic [1:0]    db;
  logic [1:0]    db_d;
  logic [1:0]    press;
  logic [CW-1:0] db_cnt [2];

  logic [0:0]    state;
  logic [PW-1:0] presc;
  logic          enable_q;

  assign raw   = {bus.Btn_step, bus.Btn_run};
  assign press = db & ~db_d;

  // Two-flop synchroniser followed by a stability-count debouncer, one lane per button.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      db_d  <= '0;
      // NOTE: db_cnt is a two-entry register array, not a RAM, so it is cleared with the rest.
      for (int i = 0; i < 2; i++) begin
        db_cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments let sync1 -> sync2 -> db shift by one stage per edge.
      sync1 <= raw;
      sync2 <= sync1;
      db_d  <= db;
      for (int i = 0; i < 2; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == CNT_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + CW'(1);
        end
      end
    end
  end

  // Run/stop FSM with prescaler; a run press always beats a simultaneous step press.
  always_ff @(posedge Clk) begin
    if (Clr) begin
      state    <= STOPPED;
      presc    <= '0;
      enable_q <= 1'b0;
    end else begin
      case (state)
        STOPPED: begin
          presc <= '0;
          if (press[BTN_RUN]) begin
            state    <= RUN;
            enable_q <= 1'b0;
          end else begin
            enable_q <= press[BTN_STEP];
          end
        end
        RUN: begin
          if (press[BTN_RUN]) begin
            state    <= STOPPED;
            presc    <= '0;
            enable_q <= 1'b0;
          end else begin
            enable_q <= (presc == PRE_LAST);
            presc    <= (presc == PRE_LAST) ? '0 : presc + PW'(1);
          end
        end
        default: begin
          state    <= STOPPED;
          presc    <= '0;
          enable_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Enable  = enable_q;
  assign bus.Running = (state == RUN);

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Directed bench for count_enable_ctrl: a DIV=4 instance for the main sequences
// and a DIV=1 instance for the continuous-enable and held-through-reset cases.
module tb_count_enable_ctrl;

  logic Clk;
  logic Clr;

  count_enable_ctrl_if m ();
  count_enable_ctrl_if d1 ();

  count_enable_ctrl #(.DIV(4), .DB_CYCLES(4)) u_dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (m)
  );

  count_enable_ctrl #(.DIV(1), .DB_CYCLES(4)) u_dut1 (
    .Clk (Clk),
    .Clr (Clr),
    .bus (d1)
  );

  int n_cmp = 0;
  int n_err = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  logic  exp_run;
  logic  exp_en;
  logic  exp_run1;
  logic  exp_en1;
  string phase;

  initial begin
    Clr         = 1'b1;
    m.Btn_run   = 1'b0;
    m.Btn_step  = 1'b0;
    d1.Btn_run  = 1'b0;
    d1.Btn_step = 1'b0;

    tick();
    tick();
    check("reset_enable",   32'(m.Enable),   32'd0);
    check("reset_running",  32'(m.Running),  32'd0);
    check("reset_enable1",  32'(d1.Enable),  32'd0);
    check("reset_running1", 32'(d1.Running), 32'd0);

    // Edge n samples the inputs driven just before it; the checks read the state after edge n.
    for (int n = 1; n <= 170; n++) begin
      Clr        = (n == 149) || (n == 150);
      m.Btn_run  = (n <= 20) || (n >= 41 && n <= 50) ||
                   (n >= 121 && n <= 123) || (n >= 136 && n <= 145);
      m.Btn_step = (n >= 25 && n <= 34) ||
                   (n >= 61 && n <= 120 && ((n - 61) % 20) < 10) ||
                   (n >= 136 && n <= 145);
      d1.Btn_run = (n >= 148);
      tick();

      if (n <= 20)       phase = "run_start";
      else if (n <= 60)  phase = "step_in_run_then_stop";
      else if (n <= 120) phase = "step_pulses";
      else if (n <= 135) phase = "glitch";
      else if (n <= 148) phase = "run_and_step_same_edge";
      else               phase = "clr_mid_run";

      // Run press first sampled at 1 -> RUN at 7, pulses at 11,15,...; stop press at 41 -> STOPPED at 47
      // (47 would have been a pulse edge). Steps start at 61,81,101 -> pulses at 67,87,107.
      // Joint press at 136 -> RUN at 142, pulse at 146; Clr at 149 with prescaler at 2.
      exp_run = (n >= 7 && n < 47) || (n >= 142 && n < 149);
      exp_en  = (n >= 11 && n < 47 && ((n - 11) % 4) == 0) ||
                (n == 67) || (n == 87) || (n == 107) ||
                (n == 146);
      // DIV=1 instance: button held across Clr release, first clean sample at 151 -> RUN at 157.
      exp_run1 = (n >= 157);
      exp_en1  = (n >= 158);

      check($sformatf("%s_running@%0d", phase, n), 32'(m.Running), 32'(exp_run));
      check($sformatf("%s_enable@%0d", phase, n),  32'(m.Enable),  32'(exp_en));
      check($sformatf("div1_running@%0d", n),      32'(d1.Running), 32'(exp_run1));
      check($sformatf("div1_enable@%0d", n),       32'(d1.Enable),  32'(exp_en1));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
